// File: rtl/hp_div_if.sv
// Handshake and operand/result bundle for the bfloat16 divider.
// The sequencer side uses the master modport; the divider uses the slave modport.
interface hp_div_if #(
  parameter int NEXP        = 8,
  parameter int NSIG        = 7,
  parameter int NTYPES      = 6,
  parameter int NEXCEPTIONS = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NEXP+NSIG:0]     a;
  logic [NEXP+NSIG:0]     b;
  logic                   out_valid;
  logic                   out_ready;
  logic [NEXP+NSIG:0]     q;
  logic [NTYPES-1:0]      bfFlags;
  logic [NEXCEPTIONS-1:0] exception;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, bfFlags, exception
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, bfFlags, exception
  );
endinterface

// File: rtl/hp_div.sv
// Multi-cycle bfloat16 divider q = a / b: restoring division, one quotient bit per cycle, RNE.
// Define HP_DIV_FTZ_EN to flush subnormal inputs and tiny results to signed zero.
module hp_div #(
  parameter int NEXP        = 8,
  parameter int NSIG        = 7,
  parameter int NTYPES      = 6,
  parameter int NEXCEPTIONS = 5
) (
  input  logic     clk,
  input  logic     rst,
  hp_div_if.slave  bus
);

  localparam int W    = NEXP + NSIG + 1;
  localparam int SIGW = NSIG + 1;
  localparam int QW   = NSIG + 3;
  localparam int RW   = SIGW + 2;
  localparam int EW   = NEXP + 2;
  localparam int SHW  = $clog2(SIGW + 1);
  localparam int CW   = $clog2(QW);
  localparam int PW   = NEXP + 1 + NSIG;

  localparam int C_ZERO = 0;
  localparam int C_SUB  = 1;
  localparam int C_NORM = 2;
  localparam int C_INF  = 3;
  localparam int C_SNAN = 4;
  localparam int C_QNAN = 5;

  localparam int X_INV = 0;
  localparam int X_DBZ = 1;
  localparam int X_OVF = 2;
  localparam int X_UNF = 3;
  localparam int X_INX = 4;

  localparam logic [EW-1:0]   BIAS_E   = EW'((1 << (NEXP - 1)) - 1);
  localparam logic [NEXP-1:0] EXP_ONES = {NEXP{1'b1}};
  localparam logic [W-1:0]    QNAN_VAL = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [NTYPES-1:0] classify(input logic [W-1:0] x);
    logic [NEXP-1:0] ex;
    logic [NSIG-1:0] fr;
    ex = x[W-2:NSIG];
    fr = x[NSIG-1:0];
    classify = {NTYPES{1'b0}};
    if (ex == {NEXP{1'b0}}) begin
      if (fr == {NSIG{1'b0}}) classify[C_ZERO] = 1'b1;
      else                    classify[C_SUB]  = 1'b1;
    end else if (ex == EXP_ONES) begin
      if (fr == {NSIG{1'b0}}) classify[C_INF]  = 1'b1;
      else if (fr[NSIG-1])    classify[C_QNAN] = 1'b1;
      else                    classify[C_SNAN] = 1'b1;
    end else begin
      classify[C_NORM] = 1'b1;
    end
  endfunction

  function automatic logic [SHW-1:0] lead_zeros(input logic [SIGW-1:0] s);
    logic found;
    found      = 1'b0;
    lead_zeros = {SHW{1'b0}};
    for (int i = SIGW - 1; i >= 0; i--) begin
      if (!found) begin
        if (s[i]) found = 1'b1;
        else      lead_zeros = lead_zeros + SHW'(1);
      end
    end
  endfunction

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic [EW-1:0]          e_q;
  logic [RW-1:0]          rem_q;
  logic [SIGW-1:0]        sigb_q;
  logic [QW-1:0]          quo_q;
  logic [CW-1:0]          cnt_q;
  logic [W-1:0]           q_q;
  logic [NTYPES-1:0]      cls_q;
  logic [NEXCEPTIONS-1:0] exc_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.bfFlags   = cls_q;
  assign bus.exception = exc_q;

  logic [NTYPES-1:0]      cls_a_s, cls_b_s;
  logic                   a_zero_s, b_zero_s, a_sub_s, b_sub_s;
  logic                   a_live_s, b_live_s;
  logic [SHW-1:0]         sh_a_s, sh_b_s;
  logic [SIGW-1:0]        sig_a_s, sig_b_s;
  logic [NEXP-1:0]        ea_s, eb_s;
  logic [EW-1:0]          e_base_s;
  logic                   sign_d;
  logic                   spec_d;
  logic [W-1:0]           spec_q_d;
  logic [NTYPES-1:0]      spec_cls_d;
  logic [NEXCEPTIONS-1:0] spec_exc_d;
  logic [EW-1:0]          prep_e_d;
  logic [RW-1:0]          prep_rem_d;

  // Operand classification, subnormal pre-normalisation and special-case selection.
  always_comb begin
    cls_a_s = classify(a_q);
    cls_b_s = classify(b_q);
`ifdef HP_DIV_FTZ_EN
    a_zero_s = cls_a_s[C_ZERO] | cls_a_s[C_SUB];
    b_zero_s = cls_b_s[C_ZERO] | cls_b_s[C_SUB];
    a_sub_s  = 1'b0;
    b_sub_s  = 1'b0;
`else
    a_zero_s = cls_a_s[C_ZERO];
    b_zero_s = cls_b_s[C_ZERO];
    a_sub_s  = cls_a_s[C_SUB];
    b_sub_s  = cls_b_s[C_SUB];
`endif
    a_live_s = cls_a_s[C_NORM] | a_sub_s;
    b_live_s = cls_b_s[C_NORM] | b_sub_s;
    sign_d   = a_q[W-1] ^ b_q[W-1];

    // A subnormal behaves as exponent 1 with its leading one shifted up to the hidden position.
    sh_a_s  = a_sub_s ? lead_zeros({1'b0, a_q[NSIG-1:0]}) : {SHW{1'b0}};
    sh_b_s  = b_sub_s ? lead_zeros({1'b0, b_q[NSIG-1:0]}) : {SHW{1'b0}};
    sig_a_s = {(a_q[W-2:NSIG] != {NEXP{1'b0}}), a_q[NSIG-1:0]} << sh_a_s;
    sig_b_s = {(b_q[W-2:NSIG] != {NEXP{1'b0}}), b_q[NSIG-1:0]} << sh_b_s;
    ea_s    = a_sub_s ? NEXP'(1) : a_q[W-2:NSIG];
    eb_s    = b_sub_s ? NEXP'(1) : b_q[W-2:NSIG];

    e_base_s = {2'b00, ea_s} - {2'b00, eb_s} + BIAS_E
             - {{(EW-SHW){1'b0}}, sh_a_s} + {{(EW-SHW){1'b0}}, sh_b_s};
    if (sig_a_s < sig_b_s) begin
      prep_rem_d = {1'b0, sig_a_s, 1'b0};
      prep_e_d   = e_base_s - EW'(1);
    end else begin
      prep_rem_d = {2'b00, sig_a_s};
      prep_e_d   = e_base_s;
    end

    spec_d     = 1'b1;
    spec_q_d   = {W{1'b0}};
    spec_cls_d = {NTYPES{1'b0}};
    spec_exc_d = {NEXCEPTIONS{1'b0}};
    if (cls_a_s[C_SNAN] | cls_a_s[C_QNAN] | cls_b_s[C_SNAN] | cls_b_s[C_QNAN]) begin
      spec_q_d          = QNAN_VAL;
      spec_cls_d[C_QNAN] = 1'b1;
      spec_exc_d[X_INV]  = cls_a_s[C_SNAN] | cls_b_s[C_SNAN];
    end else if ((a_zero_s & b_zero_s) | (cls_a_s[C_INF] & cls_b_s[C_INF])) begin
      spec_q_d          = QNAN_VAL;
      spec_cls_d[C_QNAN] = 1'b1;
      spec_exc_d[X_INV]  = 1'b1;
    end else if (cls_a_s[C_INF]) begin
      spec_q_d          = {sign_d, EXP_ONES, {NSIG{1'b0}}};
      spec_cls_d[C_INF] = 1'b1;
    end else if (b_zero_s) begin
      spec_q_d          = {sign_d, EXP_ONES, {NSIG{1'b0}}};
      spec_cls_d[C_INF] = 1'b1;
      spec_exc_d[X_DBZ] = 1'b1;
    end else if (a_live_s & b_live_s) begin
      spec_d = 1'b0;
    end else begin
      spec_q_d           = {sign_d, {(W-1){1'b0}}};
      spec_cls_d[C_ZERO] = 1'b1;
    end
  end

  logic [RW-1:0] div_rem_d;
  logic          div_bit_d;
  logic [RW-1:0] rem_diff_s;

  // One restoring step: subtract the divisor when it fits, then shift the partial remainder.
  always_comb begin
    rem_diff_s = rem_q - {2'b00, sigb_q};
    if (rem_q >= {2'b00, sigb_q}) begin
      div_bit_d = 1'b1;
      div_rem_d = {rem_diff_s[RW-2:0], 1'b0};
    end else begin
      div_bit_d = 1'b0;
      div_rem_d = {rem_q[RW-2:0], 1'b0};
    end
  end

  logic                   tiny_s;
  logic [QW-1:0]          mant_s;
  logic                   sticky_s;
  logic [NEXP:0]          exp_field_s;
  logic [NSIG-1:0]        frac_s;
  logic                   guard_s, round_s, up_s, inexact_s, ovf_s;
  logic [PW-1:0]          packed_s;
  logic [NEXP:0]          exp_res_s;
  logic [W-1:0]           rnd_q_d;
  logic [NTYPES-1:0]      rnd_cls_d;
  logic [NEXCEPTIONS-1:0] rnd_exc_d;
`ifndef HP_DIV_FTZ_EN
  localparam int          SAW     = $clog2(QW);
  localparam logic [QW-1:0] QONES = {QW{1'b1}};
  logic [EW-1:0]          sh_full_s;
  logic [SAW-1:0]         sh_s;
`endif

  // Denormalise tiny quotients, round to nearest even, and classify the packed result.
  always_comb begin
    tiny_s = e_q[EW-1] | (e_q == {EW{1'b0}});
`ifdef HP_DIV_FTZ_EN
    mant_s      = quo_q;
    sticky_s    = (rem_q != {RW{1'b0}});
    exp_field_s = e_q[NEXP:0];
`else
    sh_full_s = EW'(1) - e_q;
    sh_s      = sh_full_s[SAW-1:0];
    if (tiny_s) begin
      exp_field_s = {(NEXP+1){1'b0}};
      if (sh_full_s > EW'(QW - 1)) begin
        mant_s   = {QW{1'b0}};
        sticky_s = (rem_q != {RW{1'b0}}) | (|quo_q);
      end else begin
        mant_s   = quo_q >> sh_s;
        sticky_s = (rem_q != {RW{1'b0}}) | (|(quo_q & ~(QONES << sh_s)));
      end
    end else begin
      exp_field_s = e_q[NEXP:0];
      mant_s      = quo_q;
      sticky_s    = (rem_q != {RW{1'b0}});
    end
`endif
    frac_s    = mant_s[QW-2:2];
    guard_s   = mant_s[1];
    round_s   = mant_s[0];
    up_s      = guard_s & (round_s | sticky_s | frac_s[0]);
    inexact_s = guard_s | round_s | sticky_s;
    // The carry out of the fraction lands in the exponent, covering both 1.111.. and max-subnormal rollover.
    packed_s  = {exp_field_s, frac_s} + {{(PW-1){1'b0}}, up_s};
    exp_res_s = packed_s[PW-1:NSIG];
    ovf_s     = (exp_res_s >= {1'b0, EXP_ONES});

    rnd_q_d   = {W{1'b0}};
    rnd_cls_d = {NTYPES{1'b0}};
    rnd_exc_d = {NEXCEPTIONS{1'b0}};
`ifdef HP_DIV_FTZ_EN
    if (tiny_s) begin
      rnd_q_d            = {sign_q, {(W-1){1'b0}}};
      rnd_cls_d[C_ZERO]  = 1'b1;
      rnd_exc_d[X_UNF]   = 1'b1;
      rnd_exc_d[X_INX]   = 1'b1;
    end else
`endif
    if (ovf_s) begin
      rnd_q_d          = {sign_q, EXP_ONES, {NSIG{1'b0}}};
      rnd_cls_d[C_INF] = 1'b1;
      rnd_exc_d[X_OVF] = 1'b1;
      rnd_exc_d[X_INX] = 1'b1;
    end else begin
      rnd_q_d          = {sign_q, packed_s[PW-2:0]};
      rnd_exc_d[X_INX] = inexact_s;
      rnd_exc_d[X_UNF] = tiny_s & inexact_s;
      if (packed_s[PW-2:NSIG] != {NEXP{1'b0}}) begin
        rnd_cls_d[C_NORM] = 1'b1;
      end else if (packed_s[NSIG-1:0] != {NSIG{1'b0}}) begin
        rnd_cls_d[C_SUB] = 1'b1;
      end else begin
        rnd_cls_d[C_ZERO] = 1'b1;
      end
    end
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sign_q      <= 1'b0;
      e_q         <= {EW{1'b0}};
      rem_q       <= {RW{1'b0}};
      sigb_q      <= {SIGW{1'b0}};
      quo_q       <= {QW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      q_q         <= {W{1'b0}};
      cls_q       <= {NTYPES{1'b0}};
      exc_q       <= {NEXCEPTIONS{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            in_ready_q <= 1'b0;
            state_q    <= S_PREP;
          end
        end
        S_PREP: begin
          sign_q <= sign_d;
          if (spec_d) begin
            q_q         <= spec_q_d;
            cls_q       <= spec_cls_d;
            exc_q       <= spec_exc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            e_q     <= prep_e_d;
            rem_q   <= prep_rem_d;
            sigb_q  <= sig_b_s;
            quo_q   <= {QW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q <= div_rem_d;
          quo_q <= {quo_q[QW-2:0], div_bit_d};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          q_q         <= rnd_q_d;
          cls_q       <= rnd_cls_d;
          exc_q       <= rnd_exc_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_div.sv
// Directed, table-driven bench for hp_div; expected values are hand-computed bfloat16 quotients.
module tb_hp_div;

  localparam logic [5:0] CZ = 6'h01, CS = 6'h02, CN = 6'h04, CI = 6'h08, CQ = 6'h20;
  localparam logic [4:0] XV = 5'h01, XZ = 5'h02, XO = 5'h04, XU = 5'h08, XX = 5'h10, X0 = 5'h00;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [5:0]  cls;
    logic [4:0]  exc;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hp_div_if bus ();

  hp_div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                              input logic [5:0] c, input logic [4:0] e, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.cls = c; v.exc = e; v.lat = lat;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int hold);
    int lat;
    @(negedge clk);
    chk($sformatf("in_ready_pre %h/%h", v.a, v.b), {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'hFFFF;
    bus.b        = 16'h0000;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency %h/%h", v.a, v.b), lat, v.lat);
    chk($sformatf("q %h/%h", v.a, v.b), {16'd0, bus.q}, {16'd0, v.q});
    chk($sformatf("class %h/%h", v.a, v.b), {26'd0, bus.bfFlags}, {26'd0, v.cls});
    chk($sformatf("exc %h/%h", v.a, v.b), {27'd0, bus.exception}, {27'd0, v.exc});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_q", {16'd0, bus.q}, {16'd0, v.q});
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk($sformatf("valid_drop %h/%h", v.a, v.b), {31'd0, bus.out_valid}, 32'd0);
    chk($sformatf("in_ready_post %h/%h", v.a, v.b), {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int seen_valid;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.out_ready = 1'b0;

    vecs.push_back(mk(16'h3F80, 16'h4040, 16'h3EAB, CN, XX, 12));
    vecs.push_back(mk(16'hBF80, 16'h4040, 16'hBEAB, CN, XX, 12));
    vecs.push_back(mk(16'h4000, 16'h3FC0, 16'h3FAB, CN, XX, 12));
    vecs.push_back(mk(16'hC000, 16'h4000, 16'hBF80, CN, X0, 12));
    vecs.push_back(mk(16'h3F80, 16'h0000, 16'h7F80, CI, XZ, 1));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h7FC0, CQ, XV, 1));
    vecs.push_back(mk(16'h7F81, 16'h3F80, 16'h7FC0, CQ, XV, 1));
    vecs.push_back(mk(16'h7FC0, 16'h3F80, 16'h7FC0, CQ, X0, 1));
    vecs.push_back(mk(16'h7F80, 16'h7F80, 16'h7FC0, CQ, XV, 1));
    vecs.push_back(mk(16'hFF80, 16'h3F80, 16'hFF80, CI, X0, 1));
    vecs.push_back(mk(16'h0000, 16'hBF80, 16'h8000, CZ, X0, 1));
    vecs.push_back(mk(16'h3F80, 16'h7F80, 16'h0000, CZ, X0, 1));
    vecs.push_back(mk(16'h7F00, 16'h3F00, 16'h7F80, CI, XO | XX, 12));
`ifdef HP_DIV_FTZ_EN
    vecs.push_back(mk(16'h0080, 16'h4000, 16'h0000, CZ, XU | XX, 12));
    vecs.push_back(mk(16'h00FF, 16'h4000, 16'h0000, CZ, XU | XX, 12));
    vecs.push_back(mk(16'h0001, 16'h3F80, 16'h0000, CZ, X0, 1));
    vecs.push_back(mk(16'h0001, 16'h4000, 16'h0000, CZ, X0, 1));
    vecs.push_back(mk(16'h0003, 16'h4000, 16'h0000, CZ, X0, 1));
`else
    vecs.push_back(mk(16'h0080, 16'h4000, 16'h0040, CS, X0, 12));
    vecs.push_back(mk(16'h00FF, 16'h4000, 16'h0080, CN, XU | XX, 12));
    vecs.push_back(mk(16'h0001, 16'h3F80, 16'h0001, CS, X0, 12));
    vecs.push_back(mk(16'h0001, 16'h4000, 16'h0000, CZ, XU | XX, 12));
    vecs.push_back(mk(16'h0003, 16'h4000, 16'h0002, CS, XU | XX, 12));
`endif

    #1;
    chk("rst_q", {16'd0, bus.q}, 32'd0);
    chk("rst_class", {26'd0, bus.bfFlags}, 32'd0);
    chk("rst_exc", {27'd0, bus.exception}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Exact 3/1 with the result held three cycles before the consumer takes it.
    run_op(mk(16'h4040, 16'h3F80, 16'h4040, CN, X0, 12), 3);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 0);

    // Abort an operation mid-division; nothing may come out of it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'h4040;
    bus.b        = 16'h3F80;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_q", {16'd0, bus.q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1;
    end
    chk("abort_no_result", seen_valid, 0);
    run_op(mk(16'h4000, 16'h4000, 16'h3F80, CN, X0, 12), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hp_div.md
Name: hp_div

Overview:
- Multi-cycle bfloat16 (1/8/7) divider; computes q = a / b. It is the inverse-operation companion to the combinational multiplier in the float processing unit.
- Uses the shared class decoder (hp_class) per operand and the shared flags include for bfFlags/exception indices.
- Iterative restoring division, one quotient bit per cycle, round-to-nearest-even.
- valid/ready handshake on both sides so the FPU sequencer can stall on it.

Parameters:
- NEXP, 8, exponent width
- NSIG, 7, stored significand width (fraction bits)
- NTYPES, 6, class one-hot width (ZERO, SUBNORMAL, NORMAL, INFINITY, SNAN, QNAN)
- NEXCEPTIONS, 5, exception vector width (INVALID, DIVBYZERO, OVERFLOW, UNDERFLOW, INEXACT)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  high only in IDLE
- a  in  NEXP+NSIG+1  dividend
- b  in  NEXP+NSIG+1  divisor
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- q  out  NEXP+NSIG+1  quotient
- bfFlags  out  NTYPES  one-hot class of q
- exception  out  NEXCEPTIONS  sticky-per-op exception bits for q

Behaviour:
- Reset (async, rst=1): state IDLE, q=0, bfFlags=0, exception=0, out_valid=0, in_ready=1, all internal registers 0. Reset asserted mid-operation aborts it; no result is ever emitted.
- States: IDLE, PREP, DIV, ROUND, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready at an edge, a/b are captured and the state goes to PREP. Later input changes are ignored.
- PREP (1 cycle):
  - Classify both operands and pre-normalise subnormals to 1.xxxxxxx with a shift count.
  - Sign = sa^sb.
  - Exponent e = ea - eb + 127 - shA + shB, held in a signed register of NEXP+2 bits.
  - If sigA < sigB, sigA <<= 1 and e -= 1, so the quotient is in [1,2).
  - Special case: go directly to DONE. Otherwise go to DIV with count=0.
- Special cases, in priority order (sign xor unless stated):
  - Any NaN operand -> 0x7FC0 (sign 0), QNAN. INVALID is set only if either operand is sNaN.
  - 0/0 or inf/inf -> 0x7FC0, QNAN, INVALID.
  - inf/finite -> inf, INFINITY.
  - finite nonzero/0 -> inf, INFINITY, DIVBYZERO.
  - 0/nonzero finite, or finite/inf -> signed zero, ZERO.
- DIV (NSIG+3 = 10 cycles):
  - Restoring step per cycle: if rem >= sigB, rem -= sigB and qbit=1; then rem <<= 1.
  - Produces 1 integer bit, 7 fraction bits, guard and round. Sticky = (rem != 0).
  - After the 10th step, go to ROUND.
- ROUND (1 cycle):
  - If e <= 0: right-shift the quotient by 1-e, OR shifted-out bits into sticky, and set the exponent field to 0. If 1-e > NSIG+2, the quotient becomes all sticky.
  - RNE on guard/round/sticky. A rounding carry increments the exponent field. A subnormal that rounds to 1.0 becomes the minimum normal.
  - Exponent field >= 255 -> inf, OVERFLOW|INEXACT.
  - INEXACT = guard|round|sticky.
  - UNDERFLOW = result tiny (pre-round e <= 0) AND inexact.
  - Result 0 after rounding -> ZERO class.
  - Go to DONE.
- DONE: out_valid=1; q, bfFlags, exception are stable. On out_valid&&out_ready, go to IDLE with out_valid=0 next edge. No new operand is accepted in that same edge.
- Latency, counted in edges after the accepting edge to out_valid high:
  - special cases: 1
  - all others: 12
- Throughput: one operation in flight.

Optional Feature:
- Macro HP_DIV_FTZ_EN.
- Defined:
  - Subnormal inputs are treated as signed zero in PREP.
  - Any result with pre-round e <= 0 is flushed to signed zero, with UNDERFLOW|INEXACT set. The ROUND denormalising shifter is not built.
- Undefined: full gradual underflow as described in Behaviour.

Test Plan:
- a=0x4040 (3.0), b=0x3F80 -> q=0x4040, NORMAL, exception=0; out_valid exactly 12 edges after accept; held 3 cycles with out_ready=0, then 1 handshake.
- a=0x3F80, b=0x4040 -> q=0x3EAB, NORMAL, INEXACT only.
- a=0x3F80, b=0x0000 -> q=0x7F80, INFINITY, DIVBYZERO, latency 1. a=0x0000, b=0x0000 -> q=0x7FC0, QNAN, INVALID. a=0x7F81 (sNaN), b=0x3F80 -> 0x7FC0, INVALID.
- a=0x7F00, b=0x3F00 (0.5) -> q=0x7F80, INFINITY, OVERFLOW|INEXACT.
- a=0x0080, b=0x4000 -> q=0x0040, SUBNORMAL, exception=0. With HP_DIV_FTZ_EN -> q=0x0000, ZERO, UNDERFLOW|INEXACT.
- Assert rst during DIV (cycle 5) -> out_valid never rises; in_ready=1 immediately; a following 0x4000/0x4000 -> 0x3F80 at latency 12.
